plab5_mcore_proc2mem_adapter: RTL and testbench

- Parametrised, buffered processor-to-memory message adapter between a core's word-wide memory port and a line-wide memory/cache port.
- Carries val/rdy handshakes on all four channels and registers requests.
- Turns word reads into line-aligned full-line reads and tracks outstanding requests in order, so the correct word lane of each line response goes back to the processor.
- Passes security-domain labels through unchanged.

---
 rtl/plab5_mcore_proc2mem_adapter.sv | 205 ++++++++++++++++++++
 tb/tb_plab5_mcore_proc2mem_adapter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_proc2mem_adapter.sv
`default_nettype none
// ============================================================================
// Module   : plab5_mcore_proc2mem_adapter
// Purpose  : Buffered adapter from a word-wide processor memory port to a
//            line-wide memory port. Reads become full-line reads and the
//            correct word lane is returned using an in-order tracking FIFO.
//            Security-domain labels pass straight through.
// Revision : 1.0 - initial release
// ============================================================================
// Message layouts (MSB -> LSB):
//   request  : {type[2:0], opaque, addr, len, data}
//   response : {type[2:0], opaque, len, data}
// len is log2(data_bytes) wide (one bit minimum); len==0 means a full word/line.
module plab5_mcore_proc2mem_adapter #(
  parameter int opaque_nbits    = 8,
  parameter int addr_nbits      = 32,
  parameter int proc_data_nbits = 32,
  parameter int mem_data_nbits  = 128,
  parameter int max_outstanding = 4,

  localparam int PLEN_W     = (proc_data_nbits > 8) ? $clog2(proc_data_nbits / 8) : 1,
  localparam int MLEN_W     = (mem_data_nbits  > 8) ? $clog2(mem_data_nbits  / 8) : 1,
  localparam int PREQ_NBITS = 3 + opaque_nbits + addr_nbits + PLEN_W + proc_data_nbits,
  localparam int MREQ_NBITS = 3 + opaque_nbits + addr_nbits + MLEN_W + mem_data_nbits,
  localparam int PRSP_NBITS = 3 + opaque_nbits + PLEN_W + proc_data_nbits,
  localparam int MRSP_NBITS = 3 + opaque_nbits + MLEN_W + mem_data_nbits
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_domain,
  input  logic                  resp_domain,

  input  logic                  proc_req_val,
  output logic                  proc_req_rdy,
  input  logic [PREQ_NBITS-1:0] proc_req_msg,

  output logic                  mem_req_val,
  input  logic                  mem_req_rdy,
  output logic [MREQ_NBITS-1:0] mem_req_msg,
  output logic                  mem_req_domain,

  input  logic                  mem_resp_val,
  output logic                  mem_resp_rdy,
  input  logic [MRSP_NBITS-1:0] mem_resp_msg,

  output logic                  proc_resp_val,
  input  logic                  proc_resp_rdy,
  output logic [PRSP_NBITS-1:0] proc_resp_msg,
  output logic                  proc_resp_domain
);

  localparam int LANES    = mem_data_nbits / proc_data_nbits;
  localparam int OFF_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WORD_LSB = $clog2(proc_data_nbits / 8);
  localparam int LINE_LSB = $clog2(mem_data_nbits / 8);
  localparam int PTR_W    = $clog2(max_outstanding);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [2:0]            TYPE_WRITE = 3'd1;
  localparam logic [MLEN_W-1:0]     WLEN_FULL  = MLEN_W'(proc_data_nbits / 8);
  localparam logic [addr_nbits-1:0] LINE_MASK  = addr_nbits'((1 << LINE_LSB) - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(max_outstanding);

  // ---------------------------------------------------------------- fields
  logic [2:0]                 w_preq_type;
  logic [opaque_nbits-1:0]    w_preq_opq;
  logic [addr_nbits-1:0]      w_preq_addr;
  logic [PLEN_W-1:0]          w_preq_len;
  logic [proc_data_nbits-1:0] w_preq_data;
  logic [OFF_W-1:0]           w_preq_off;

  assign {w_preq_type, w_preq_opq, w_preq_addr, w_preq_len, w_preq_data} = proc_req_msg;

  logic [2:0]                w_mresp_type;
  logic [opaque_nbits-1:0]   w_mresp_opq;
  logic [MLEN_W-1:0]         w_mresp_len;
  logic [mem_data_nbits-1:0] w_mresp_data;

  assign {w_mresp_type, w_mresp_opq, w_mresp_len, w_mresp_data} = mem_resp_msg;

  // The memory-side response length carries nothing the processor needs.
  logic w_unused;
  assign w_unused = &{1'b0, w_mresp_len};

  generate
    if (LANES > 1) begin : g_lane_off
      assign w_preq_off = w_preq_addr[WORD_LSB +: OFF_W];
    end else begin : g_single_lane
      assign w_preq_off = '0;
    end
  endgenerate

  // ------------------------------------------------------------ state
  logic                  mem_req_val_q;
  logic [MREQ_NBITS-1:0] mem_req_msg_q;
  logic                  mem_req_dom_q;

  logic [2:0]        fifo_type_q [max_outstanding];
  logic [OFF_W-1:0]  fifo_off_q  [max_outstanding];
  logic [PLEN_W-1:0] fifo_len_q  [max_outstanding];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic w_push, w_pop, w_not_empty;

  // -------------------------------------------------------- handshakes
  assign w_not_empty  = (count_q != '0);
  assign proc_req_rdy = (!mem_req_val_q || mem_req_rdy) && (count_q < CNT_MAX);
  assign w_push       = proc_req_val && proc_req_rdy;
  assign mem_resp_rdy = proc_resp_rdy && w_not_empty;
  assign proc_resp_val = mem_resp_val && w_not_empty;
  assign w_pop        = proc_resp_val && proc_resp_rdy;

  // Translate a word request into its memory-side form.
  logic [addr_nbits-1:0]     w_mreq_addr;
  logic [MLEN_W-1:0]         w_mreq_len;
  logic [mem_data_nbits-1:0] w_mreq_data;

  // Reads fetch the whole aligned line; writes keep the word in the low lane.
  always_comb begin
    w_mreq_addr = w_preq_addr;
    w_mreq_len  = '0;
    w_mreq_data = '0;
    if (w_preq_type == TYPE_WRITE) begin
      if (w_preq_len == '0) begin
        w_mreq_len = WLEN_FULL;
      end else begin
        w_mreq_len[PLEN_W-1:0] = w_preq_len;
      end
      w_mreq_data[proc_data_nbits-1:0] = w_preq_data;
    end else begin
      w_mreq_addr = w_preq_addr & ~LINE_MASK;
    end
  end

  // One-entry request register; load on accept, clear once drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_val_q <= 1'b0;
      mem_req_msg_q <= '0;
      mem_req_dom_q <= 1'b0;
    end else if (w_push) begin
      mem_req_val_q <= 1'b1;
      mem_req_msg_q <= {w_preq_type, w_preq_opq, w_mreq_addr, w_mreq_len, w_mreq_data};
      mem_req_dom_q <= req_domain;
    end else if (mem_req_rdy) begin
      mem_req_val_q <= 1'b0;
    end
  end

  assign mem_req_val    = mem_req_val_q;
  assign mem_req_msg    = mem_req_msg_q;
  assign mem_req_domain = mem_req_dom_q;

  // Occupancy follows push/pop; a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (w_pop && !w_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // In-order tracking FIFO of {type, lane offset, proc len} per request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < max_outstanding; i++) begin
        fifo_type_q[i] <= '0;
        fifo_off_q[i]  <= '0;
        fifo_len_q[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        fifo_type_q[wr_ptr_q] <= w_preq_type;
        fifo_off_q[wr_ptr_q]  <= w_preq_off;
        fifo_len_q[wr_ptr_q]  <= w_preq_len;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------- response path
  logic [proc_data_nbits-1:0] w_presp_data;

  // Pick the word lane of the line for reads; writes return no data.
  always_comb begin
    w_presp_data = '0;
    if (fifo_type_q[rd_ptr_q] != TYPE_WRITE) begin
      w_presp_data = w_mresp_data[fifo_off_q[rd_ptr_q] * proc_data_nbits +: proc_data_nbits];
    end
  end

  assign proc_resp_msg    = {w_mresp_type, w_mresp_opq, fifo_len_q[rd_ptr_q], w_presp_data};
  assign proc_resp_domain = resp_domain;

endmodule
`default_nettype wire

// File: tb/tb_plab5_mcore_proc2mem_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_plab5_mcore_proc2mem_adapter
// Purpose  : Directed self-checking bench for the proc-to-mem adapter using
//            default parameters (o=8, a=32, pd=32, md=128, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_plab5_mcore_proc2mem_adapter;

  localparam int PREQ = 77;
  localparam int MREQ = 175;
  localparam int PRSP = 45;
  localparam int MRSP = 143;

  localparam logic [127:0] LINE = 128'hDDDDCCCC_BBBBAAAA_99998888_77776666;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_domain, resp_domain;
  logic            proc_req_val, proc_req_rdy;
  logic [PREQ-1:0] proc_req_msg;
  logic            mem_req_val, mem_req_rdy;
  logic [MREQ-1:0] mem_req_msg;
  logic            mem_req_domain;
  logic            mem_resp_val, mem_resp_rdy;
  logic [MRSP-1:0] mem_resp_msg;
  logic            proc_resp_val, proc_resp_rdy;
  logic [PRSP-1:0] proc_resp_msg;
  logic            proc_resp_domain;

  int n_checks = 0;
  int n_errors = 0;

  plab5_mcore_proc2mem_adapter dut (
    .clk              (clk),
    .reset            (reset),
    .req_domain       (req_domain),
    .resp_domain      (resp_domain),
    .proc_req_val     (proc_req_val),
    .proc_req_rdy     (proc_req_rdy),
    .proc_req_msg     (proc_req_msg),
    .mem_req_val      (mem_req_val),
    .mem_req_rdy      (mem_req_rdy),
    .mem_req_msg      (mem_req_msg),
    .mem_req_domain   (mem_req_domain),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_rdy     (mem_resp_rdy),
    .mem_resp_msg     (mem_resp_msg),
    .proc_resp_val    (proc_resp_val),
    .proc_resp_rdy    (proc_resp_rdy),
    .proc_resp_msg    (proc_resp_msg),
    .proc_resp_domain (proc_resp_domain)
  );

  always #5 clk = ~clk;

  function automatic logic [PREQ-1:0] preq(input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [1:0] l,
                                           input logic [31:0] d);
    return {t, o, a, l, d};
  endfunction

  function automatic logic [MREQ-1:0] mreq(input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [3:0] l,
                                           input logic [127:0] d);
    return {t, o, a, l, d};
  endfunction

  function automatic logic [MRSP-1:0] mresp(input logic [2:0] t, input logic [7:0] o,
                                            input logic [3:0] l, input logic [127:0] d);
    return {t, o, l, d};
  endfunction

  function automatic logic [PRSP-1:0] presp(input logic [2:0] t, input logic [7:0] o,
                                            input logic [1:0] l, input logic [31:0] d);
    return {t, o, l, d};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one memory response and check the processor-side result.
  task automatic respond(input string tag, input logic [2:0] t, input logic [7:0] o,
                         input logic [31:0] exp_data);
    mem_resp_val  = 1'b1;
    mem_resp_msg  = mresp(t, o, 4'd0, LINE);
    proc_resp_rdy = 1'b1;
    #1;
    check({tag, "_val"}, 256'(proc_resp_val), 256'(1'b1));
    check({tag, "_msg"}, 256'(proc_resp_msg), 256'(presp(t, o, 2'd0, exp_data)));
    tick();
    mem_resp_val = 1'b0;
  endtask

  logic [31:0] exp_lane [4];
  logic [31:0] addr4 [4];

  initial begin
    reset = 1'b1; req_domain = 1'b0; resp_domain = 1'b0;
    proc_req_val = 1'b0; proc_req_msg = '0; mem_req_rdy = 1'b0;
    mem_resp_val = 1'b0; mem_resp_msg = '0; proc_resp_rdy = 1'b0;
    #2;
    check("rst_mreq_val", 256'(mem_req_val), 256'(1'b0));
    check("rst_mreq_msg", 256'(mem_req_msg), 256'(0));
    check("rst_mreq_dom", 256'(mem_req_domain), 256'(1'b0));
    check("rst_presp_val", 256'(proc_resp_val), 256'(1'b0));
    check("rst_mresp_rdy", 256'(mem_resp_rdy), 256'(1'b0));
    tick(); tick();
    reset = 1'b0;

    // ---- single read, lane 2
    req_domain   = 1'b1;
    proc_req_val = 1'b1;
    proc_req_msg = preq(3'd0, 8'h05, 32'h1008, 2'd0, 32'h0);
    #1;
    check("rd_preq_rdy", 256'(proc_req_rdy), 256'(1'b1));
    tick();
    proc_req_val = 1'b0;
    check("rd_mreq_val", 256'(mem_req_val), 256'(1'b1));
    check("rd_mreq_msg", 256'(mem_req_msg), 256'(mreq(3'd0, 8'h05, 32'h1000, 4'd0, 128'h0)));
    check("rd_mreq_dom", 256'(mem_req_domain), 256'(1'b1));
    mem_req_rdy = 1'b1;
    tick();
    check("rd_mreq_drop", 256'(mem_req_val), 256'(1'b0));
    resp_domain = 1'b1;
    #1;
    check("rd_presp_dom", 256'(proc_resp_domain), 256'(1'b1));
    respond("rd_resp", 3'd0, 8'h05, 32'hBBBBAAAA);
    #1;
    check("rd_empty_rdy", 256'(mem_resp_rdy), 256'(1'b0));

    // ---- single write
    req_domain   = 1'b0;
    proc_req_val = 1'b1;
    proc_req_msg = preq(3'd1, 8'h11, 32'h2004, 2'd0, 32'hDEADBEEF);
    tick();
    proc_req_val = 1'b0;
    check("wr_mreq_msg", 256'(mem_req_msg),
          256'(mreq(3'd1, 8'h11, 32'h2004, 4'd4, 128'hDEADBEEF)));
    check("wr_mreq_dom", 256'(mem_req_domain), 256'(1'b0));
    tick();
    respond("wr_resp", 3'd1, 8'h11, 32'h0);

    // ---- four reads fill the tracking FIFO, fifth is refused
    addr4    = '{32'h300C, 32'h3004, 32'h3000, 32'h3008};
    exp_lane = '{32'hDDDDCCCC, 32'h99998888, 32'h77776666, 32'hBBBBAAAA};
    for (int i = 0; i < 4; i++) begin
      proc_req_val = 1'b1;
      proc_req_msg = preq(3'd0, 8'(8'h20 + i), addr4[i], 2'd0, 32'h0);
      #1;
      check($sformatf("fill_rdy%0d", i), 256'(proc_req_rdy), 256'(1'b1));
      tick();
    end
    proc_req_msg = preq(3'd0, 8'h24, 32'h3010, 2'd0, 32'h0);
    #1;
    check("full_rdy", 256'(proc_req_rdy), 256'(1'b0));
    check("full_last_mreq", 256'(mem_req_msg), 256'(mreq(3'd0, 8'h23, 32'h3000, 4'd0, 128'h0)));
    proc_req_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      respond($sformatf("fill_resp%0d", i), 3'd0, 8'(8'h20 + i), exp_lane[i]);
    end
    mem_resp_val = 1'b1;
    #1;
    check("drained_mresp_rdy", 256'(mem_resp_rdy), 256'(1'b0));
    check("drained_presp_val", 256'(proc_resp_val), 256'(1'b0));
    mem_resp_val = 1'b0;

    // ---- push and pop on the same edge keeps count at one
    proc_req_val = 1'b1;
    proc_req_msg = preq(3'd0, 8'h30, 32'h4004, 2'd0, 32'h0);
    tick();
    proc_req_msg = preq(3'd0, 8'h31, 32'h4008, 2'd0, 32'h0);
    respond("pp_resp0", 3'd0, 8'h30, 32'h99998888);
    proc_req_val = 1'b0;
    #1;
    check("pp_cnt1_rdy", 256'(mem_resp_rdy), 256'(1'b1));
    respond("pp_resp1", 3'd0, 8'h31, 32'hBBBBAAAA);
    #1;
    check("pp_cnt0_rdy", 256'(mem_resp_rdy), 256'(1'b0));

    // ---- backpressure holds the buffered request and its domain
    mem_req_rdy  = 1'b0;
    req_domain   = 1'b1;
    proc_req_val = 1'b1;
    proc_req_msg = preq(3'd0, 8'h40, 32'h5014, 2'd0, 32'h0);
    tick();
    req_domain   = 1'b0;
    proc_req_msg = preq(3'd0, 8'h41, 32'h5018, 2'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_rdy%0d", i), 256'(proc_req_rdy), 256'(1'b0));
      check($sformatf("bp_msg%0d", i), 256'(mem_req_msg),
            256'(mreq(3'd0, 8'h40, 32'h5010, 4'd0, 128'h0)));
      check($sformatf("bp_dom%0d", i), 256'(mem_req_domain), 256'(1'b1));
      tick();
    end
    mem_req_rdy = 1'b1;
    #1;
    check("bp_release_rdy", 256'(proc_req_rdy), 256'(1'b1));
    tick();
    check("b2b_msg_b", 256'(mem_req_msg), 256'(mreq(3'd0, 8'h41, 32'h5010, 4'd0, 128'h0)));
    check("b2b_dom_b", 256'(mem_req_domain), 256'(1'b0));
    proc_req_msg = preq(3'd0, 8'h42, 32'h501C, 2'd0, 32'h0);
    tick();
    check("b2b_val_c", 256'(mem_req_val), 256'(1'b1));
    check("b2b_msg_c", 256'(mem_req_msg), 256'(mreq(3'd0, 8'h42, 32'h5010, 4'd0, 128'h0)));
    proc_req_val = 1'b0;
    tick();
    check("b2b_idle", 256'(mem_req_val), 256'(1'b0));
    respond("bp_resp_a", 3'd0, 8'h40, 32'h99998888);
    respond("bp_resp_b", 3'd0, 8'h41, 32'hBBBBAAAA);
    respond("bp_resp_c", 3'd0, 8'h42, 32'hDDDDCCCC);

    // ---- asynchronous reset with requests in flight
    proc_req_val = 1'b1;
    proc_req_msg = preq(3'd0, 8'h50, 32'h6000, 2'd0, 32'h0);
    tick();
    proc_req_msg = preq(3'd0, 8'h51, 32'h6004, 2'd0, 32'h0);
    tick();
    mem_req_rdy  = 1'b0;
    req_domain   = 1'b1;
    proc_req_msg = preq(3'd0, 8'h52, 32'h6008, 2'd0, 32'h0);
    tick();
    proc_req_val  = 1'b0;
    mem_resp_val  = 1'b1;
    mem_resp_msg  = mresp(3'd0, 8'h50, 4'd0, LINE);
    proc_resp_rdy = 1'b0;
    #1;
    check("pre_rst_presp_val", 256'(proc_resp_val), 256'(1'b1));
    check("pre_rst_mreq_val", 256'(mem_req_val), 256'(1'b1));
    #1;
    reset = 1'b1;
    #1;
    check("arst_mreq_val", 256'(mem_req_val), 256'(1'b0));
    check("arst_mreq_msg", 256'(mem_req_msg), 256'(0));
    check("arst_mreq_dom", 256'(mem_req_domain), 256'(1'b0));
    check("arst_presp_val", 256'(proc_resp_val), 256'(1'b0));
    tick();
    reset = 1'b0;
    proc_resp_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("stray_rdy%0d", i), 256'(mem_resp_rdy), 256'(1'b0));
      check($sformatf("stray_val%0d", i), 256'(proc_resp_val), 256'(1'b0));
      tick();
    end
    mem_resp_val = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
